// File: rtl/fila_arbiter.sv
// Req/ack arbiter in front of the byte queue: two producers and one consumer share one command port.
// Optional consistency check against the queue's reported length is enabled by `define FILA_ARB_CHECK_EN.
module fila_arbiter #(
    parameter int DEPTH       = 8,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              req0_in,
    input  logic [DATA_W-1:0] data0_in,
    output logic              ack0_out,
    input  logic              req1_in,
    input  logic [DATA_W-1:0] data1_in,
    output logic              ack1_out,
    input  logic              deq_req_in,
    output logic              deq_ack_out,
    input  logic [7:0]        len_in,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        count_out,
    output logic              full_out,
    output logic              empty_out
`ifdef FILA_ARB_CHECK_EN
    ,
    output logic              err_out
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2, RELEASE = 2'd3} state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              last_op_q, last_op_d;
    logic              win_id_q, win_id_d;
    logic              win_deq_q, win_deq_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        count_q, count_d;
    logic [3:0]        hold_q, hold_d;

    logic can_enq, can_deq, el0, el1, eld, pick, win_req, block;

    assign can_enq = (count_q != DEPTH_C);
    assign can_deq = (count_q != 4'd0);
    assign el0     = req0_in & can_enq;
    assign el1     = req1_in & can_enq;
    assign eld     = deq_req_in & can_deq;
    assign pick    = (el0 & el1) ? rr_q : el1;
    assign win_req = win_deq_q ? deq_req_in : (win_id_q ? req1_in : req0_in);

`ifdef FILA_ARB_CHECK_EN
    logic err_q, err_d, mismatch;
    assign mismatch = (len_in != {4'd0, count_q});
    assign block    = err_q | mismatch;
    assign err_out  = err_q;
`else
    logic unused_len;
    assign unused_len = ^len_in;
    assign block      = 1'b0;
`endif

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            last_op_q <= 1'b0;
            win_id_q  <= 1'b0;
            win_deq_q <= 1'b0;
            data_q    <= '0;
            count_q   <= 4'd0;
            hold_q    <= 4'd0;
`ifdef FILA_ARB_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            last_op_q <= last_op_d;
            win_id_q  <= win_id_d;
            win_deq_q <= win_deq_d;
            data_q    <= data_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
`ifdef FILA_ARB_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        last_op_d = last_op_q;
        win_id_d  = win_id_q;
        win_deq_d = win_deq_q;
        data_d    = data_q;
        count_d   = count_q;
        hold_d    = hold_q;
`ifdef FILA_ARB_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef FILA_ARB_CHECK_EN
                err_d = err_q | mismatch;
`endif
                if (!block && (el0 | el1 | eld)) begin
                    state_d = ISSUE;
                    // Contention between enqueue and dequeue alternates via last_op.
                    if (eld && (!(el0 | el1) || !last_op_q)) begin
                        win_deq_d = 1'b1;
                        last_op_d = 1'b1;
                    end else begin
                        win_deq_d = 1'b0;
                        last_op_d = 1'b0;
                        win_id_d  = pick;
                        rr_d      = ~pick;
                        data_d    = pick ? data1_in : data0_in;
                    end
                end
            end
            ISSUE: begin
                count_d = win_deq_q ? (count_q - 4'd1) : (count_q + 4'd1);
                hold_d  = HOLD_LD;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == 4'd0) state_d = RELEASE;
                else                hold_d  = hold_q - 4'd1;
            end
            RELEASE: begin
                if (!win_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enqueue_out = (state_q == ISSUE) & ~win_deq_q;
        dequeue_out = (state_q == ISSUE) &  win_deq_q;
        ack0_out    = (state_q == RELEASE) & ~win_deq_q & ~win_id_q;
        ack1_out    = (state_q == RELEASE) & ~win_deq_q &  win_id_q;
        deq_ack_out = (state_q == RELEASE) &  win_deq_q;
    end

    assign data_out  = data_q;
    assign count_out = count_q;
    assign full_out  = (count_q == DEPTH_C);
    assign empty_out = (count_q == 4'd0);

endmodule

// File: tb/tb_fila_arbiter.sv
// Directed bench for fila_arbiter: scoreboard of expected enqueue/dequeue commands
// checked by a monitor, plus direct checks of ack timing, occupancy and reset.
module tb_fila_arbiter;

    typedef struct packed {
        logic       deq;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, deq_req = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, deq_ack, enq, deq, full, empty;
    logic [7:0] dout;
    logic [3:0] count;
    logic [7:0] len;
    logic       len_ovr = 1'b0;
    logic [7:0] len_val = 8'h00;
`ifdef FILA_ARB_CHECK_EN
    logic       err;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Models the queue's own length report.
    assign len = len_ovr ? len_val : {4'd0, count};

    fila_arbiter #(.DEPTH(8), .DATA_W(8), .HOLD_CYCLES(2)) dut (
        .clock_10KHz(clk),
        .reset      (rst),
        .req0_in    (req0),
        .data0_in   (data0),
        .ack0_out   (ack0),
        .req1_in    (req1),
        .data1_in   (data1),
        .ack1_out   (ack1),
        .deq_req_in (deq_req),
        .deq_ack_out(deq_ack),
        .len_in     (len),
        .enqueue_out(enq),
        .dequeue_out(deq),
        .data_out   (dout),
        .count_out  (count),
        .full_out   (full),
        .empty_out  (empty)
`ifdef FILA_ARB_CHECK_EN
        ,
        .err_out    (err)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every command pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (enq || deq)) begin
            if (enq && deq) begin
                check("pulse_overlap", {enq, deq}, 2'b10);
            end else if (sb.size() == 0) begin
                check("unexpected_pulse", {enq, deq}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_op", deq, e.deq);
                if (enq) check("sb_data", dout, e.data);
            end
        end
    end

    function automatic logic pick_sig(input int sel);
        case (sel)
            0:       return ack0;
            1:       return ack1;
            default: return deq_ack;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (pick_sig(sel) == lvl) return;
        end
        check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_any(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ack0 || ack1 || deq_ack) return;
        end
        check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic set_req(input int k, input logic v);
        if (k == 0) req0 = v;
        else if (k == 1) req1 = v;
        else deq_req = v;
    endtask

    task automatic enq_txn(input int k, input logic [7:0] d);
        sb.push_back('{deq: 1'b0, data: d});
        @(posedge clk); #1;
        if (k == 0) data0 = d; else data1 = d;
        set_req(k, 1'b1);
        wait_level(k, 1'b1, "enq_ack");
        set_req(k, 1'b0);
        wait_level(k, 1'b0, "enq_ack_low");
    endtask

    task automatic do_reset();
        check("sb_drain", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; deq_req = 1'b0; len_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_acks", {ack0, ack1, deq_ack}, 3'b000);
        check("rst_pulses", {enq, deq}, 2'b00);
        check("rst_data", dout, 8'h00);
        check("rst_count", count, 4'd0);
        check("rst_flags", {empty, full}, 2'b10);
        @(posedge clk); #1 rst = 1'b0;

        // Single enqueue with ack latency
        sb.push_back('{deq: 1'b0, data: 8'hA5});
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 8'hA5;
        repeat (3) @(posedge clk);
        #1 check("ack0_early", ack0, 1'b0);
        @(posedge clk);
        #1 check("ack0_rise", ack0, 1'b1);
        req0 = 1'b0;
        @(posedge clk);
        #1 check("ack0_fall", ack0, 1'b0);
        check("t1_count", count, 4'd1);
        check("t1_empty", empty, 1'b0);

        // Round-robin between two producers
        do_reset();
        sb.push_back('{deq: 1'b0, data: 8'h10});
        sb.push_back('{deq: 1'b0, data: 8'h20});
        sb.push_back('{deq: 1'b0, data: 8'h30});
        sb.push_back('{deq: 1'b0, data: 8'h40});
        data0 = 8'h10; data1 = 8'h20;
        req0 = 1'b1; req1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int w;
            wait_any("rr_ack");
            w = ack1 ? 1 : 0;
            check("rr_winner", w, r % 2);
            set_req(w, 1'b0);
            wait_level(w, 1'b0, "rr_ack_low");
            if (r < 2) begin
                if (w == 0) data0 = 8'h30; else data1 = 8'h40;
                set_req(w, 1'b1);
            end
        end
        check("rr_count", count, 4'd4);

        // Fill to full; blocked enqueue waits for a dequeue
        for (int i = 0; i < 4; i++) enq_txn(0, 8'h80 + 8'(i));
        check("fill_count", count, 4'd8);
        check("fill_full", full, 1'b1);
        sb.push_back('{deq: 1'b1, data: 8'h00});
        sb.push_back('{deq: 1'b0, data: 8'h77});
        data1 = 8'h77; req1 = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("full_blocks_ack1", ack1, 1'b0);
        check("full_hold_count", count, 4'd8);
        deq_req = 1'b1;
        wait_level(2, 1'b1, "deq_ack");
        check("deq_count", count, 4'd7);
        check("deq_not_full", full, 1'b0);
        deq_req = 1'b0;
        wait_level(2, 1'b0, "deq_ack_low");
        wait_level(1, 1'b1, "ack1_after_deq");
        req1 = 1'b0;
        wait_level(1, 1'b0, "ack1_low");
        check("refill_count", count, 4'd8);

        // Alternating enqueue/dequeue from count 3
        do_reset();
        for (int i = 0; i < 3; i++) enq_txn(0, 8'h01 + 8'(i));
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{deq: 1'b1, data: 8'h00});
            sb.push_back('{deq: 1'b0, data: 8'h55});
        end
        data0 = 8'h55; req0 = 1'b1; deq_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int w;
            wait_any("alt_ack");
            w = deq_ack ? 2 : 0;
            check("alt_op", w, (r % 2 == 0) ? 2 : 0);
            check("alt_count", count, (r % 2 == 0) ? 4'd2 : 4'd3);
            set_req(w, 1'b0);
            if (r == 3) begin
                req0 = 1'b0; deq_req = 1'b0;
            end
            wait_level(w, 1'b0, "alt_ack_low");
            if (r < 3) set_req(w, 1'b1);
        end

        // Reset during HOLD aborts the command
        do_reset();
        sb.push_back('{deq: 1'b0, data: 8'h99});
        @(posedge clk); #1;
        req0 = 1'b1; data0 = 8'h99;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        req0 = 1'b0;
        #1;
        check("abort_count", count, 4'd0);
        check("abort_outs", {ack0, ack1, deq_ack, enq, deq}, 5'b00000);
        check("abort_data", dout, 8'h00);
        check("abort_empty", empty, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("abort_no_ack", ack0, 1'b0);
        check("abort_count2", count, 4'd0);
        enq_txn(0, 8'h3C);
        check("post_abort_count", count, 4'd1);

`ifdef FILA_ARB_CHECK_EN
        // Length mismatch sets sticky error and blocks grants
        do_reset();
        check("err_rst", err, 1'b0);
        enq_txn(0, 8'h11);
        enq_txn(1, 8'h22);
        @(posedge clk); #1;
        len_val = 8'd5; len_ovr = 1'b1;
        @(posedge clk); #1;
        check("err_set", err, 1'b1);
        len_ovr = 1'b0;
        req0 = 1'b1; data0 = 8'h33;
        repeat (15) @(posedge clk);
        #1 check("err_blocks", ack0, 1'b0);
        check("err_sticky", err, 1'b1);
        check("err_count", count, 4'd2);
        req0 = 1'b0;
`endif

        repeat (3) @(posedge clk);
        check("sb_final_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
